// File: rtl/i2s_tx_src_arbiter.sv
// i2s_tx_src_arbiter
// Arbitrates two stereo sample sources onto the DAC FIFO write port of the
// I2S transmitter. The arbiter can pick s0 only, s1 only, round-robin between
// them, or mix the two sources. It writes at most one word per clock and
// stops writing while the FIFO reports full.
// Optional build macro: I2S_ARB_MIX_SAT_EN. When it is defined, the mixed
// halves saturate. When it is undefined, they wrap.
module i2s_tx_src_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  dacfifo_wrclk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  s0_valid,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  input  logic                  dacfifo_full,
  output logic                  dacfifo_wren,
  output logic [DATA_WIDTH-1:0] dacfifo_wrdata,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int HALF = DATA_WIDTH / 2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SWITCH = 1'b1
  } state_t;

  // Control state
  state_t                state_q,   state_d;
  logic [1:0]            mode_r_q,  mode_r_d;
  logic                  rr_last_q, rr_last_d;  // 0 = s0 won last, 1 = s1 won last

  // Registered write port
  logic                  wren_q,    wren_d;
  logic [DATA_WIDTH-1:0] wrdata_q,  wrdata_d;
  logic [1:0]            grant_q,   grant_d;

  // Selection intermediates
  logic                  sel_ok;
  logic                  take0;
  logic                  take1;
  logic                  issue;
  logic [DATA_WIDTH-1:0] mix_data;

  // Sum each stereo half on its own as a signed value.
  // gi = 0 is the right half and gi = 1 is the left half.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
`ifdef I2S_ARB_MIX_SAT_EN
      // One guard bit detects overflow. A sign mismatch between the top two
      // bits means the true sum does not fit, so the half clamps toward that sign.
      logic signed [HALF:0] sum;
      assign sum = {s0_data[gi*HALF+HALF-1], s0_data[gi*HALF +: HALF]}
                 + {s1_data[gi*HALF+HALF-1], s1_data[gi*HALF +: HALF]};
      assign mix_data[gi*HALF +: HALF] =
          (sum[HALF] == sum[HALF-1]) ? sum[HALF-1:0] :
          (sum[HALF] ? {1'b1, {(HALF-1){1'b0}}}      // most negative
                     : {1'b0, {(HALF-1){1'b1}}});    // most positive
`else
      // Two's-complement wrap: keep only the low HALF bits of the sum.
      logic [HALF-1:0] sum;
      assign sum = s0_data[gi*HALF +: HALF] + s1_data[gi*HALF +: HALF];
      assign mix_data[gi*HALF +: HALF] = sum;
`endif
    end
  endgenerate

  // Source selection, issue decision, next-state logic and write-data mux
  always_comb begin
    state_d   = state_q;
    mode_r_d  = mode_r_q;
    rr_last_d = rr_last_q;
    sel_ok    = 1'b0;
    take0     = 1'b0;
    take1     = 1'b0;
    wren_d    = 1'b0;
    wrdata_d  = wrdata_q;
    grant_d   = grant_q;

    case (mode_r_q)
      2'b00: begin
        sel_ok = s0_valid;
        take0  = 1'b1;
      end
      2'b01: begin
        sel_ok = s1_valid;
        take1  = 1'b1;
      end
      2'b10: begin
        sel_ok = s0_valid | s1_valid;
        if (s0_valid && s1_valid) begin
          // On a tie, grant the source that did not win last time.
          take0 = rr_last_q;
          take1 = ~rr_last_q;
        end else begin
          take0 = s0_valid;
          take1 = ~s0_valid;
        end
      end
      default: begin
        sel_ok = s0_valid & s1_valid;
        take0  = 1'b1;
        take1  = 1'b1;
      end
    endcase

    // A pending mode change blocks issue in the same cycle. Reset also
    // blocks issue, so no source sees ready while reset is asserted.
    issue = reset_n && (state_q == ST_RUN) && (mode == mode_r_q) &&
            enable && !dacfifo_full && sel_ok;

    case (state_q)
      ST_RUN: begin
        if (mode != mode_r_q) begin
          state_d = ST_SWITCH;
        end else if (issue && (mode_r_q == 2'b10)) begin
          rr_last_d = take1;
        end
      end
      default: begin
        state_d   = ST_RUN;
        mode_r_d  = mode;
        rr_last_d = 1'b1;
      end
    endcase

    if (issue) begin
      wren_d  = 1'b1;
      grant_d = {take1, take0};
      case ({take1, take0})
        2'b01:   wrdata_d = s0_data;
        2'b10:   wrdata_d = s1_data;
        default: wrdata_d = mix_data;
      endcase
    end
  end

  // State and write-port registers with synchronous active-low reset
  always_ff @(posedge dacfifo_wrclk) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      mode_r_q  <= 2'b00;
      rr_last_q <= 1'b1;
      wren_q    <= 1'b0;
      wrdata_q  <= '0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      mode_r_q  <= mode_r_d;
      rr_last_q <= rr_last_d;
      wren_q    <= wren_d;
      wrdata_q  <= wrdata_d;
      grant_q   <= grant_d;
    end
  end

  assign s0_ready       = issue & take0;
  assign s1_ready       = issue & take1;
  assign dacfifo_wren   = wren_q;
  assign dacfifo_wrdata = wrdata_q;
  assign grant          = grant_q;
  assign busy           = (state_q == ST_SWITCH);

endmodule
